// File: rtl/codix_risc_dbus_timer.sv
// codix_risc_dbus_timer: 32-bit memory-mapped timer that answers core data bus requests
// Ports: CLK, RST (async, active-low); dbus_A0/SI0/SC0/REQCMD0 request in, dbus_REQRESP0 accept out;
//        dbus_Q0/IFRESP0 read data out with dbus_IFCMD0 taker; dbus_D0/OFCMD0 write data in with dbus_OFRESP0;
//        irq level interrupt (MATCH & IRQEN). Registers: 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS.
module codix_risc_dbus_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] dbus_A0,
   input  logic [1:0]  dbus_SI0,
   input  logic [3:0]  dbus_SC0,
   input  logic [1:0]  dbus_REQCMD0,
   output logic [1:0]  dbus_REQRESP0,
   output logic [31:0] dbus_Q0,
   input  logic        dbus_IFCMD0,
   output logic [1:0]  dbus_IFRESP0,
   input  logic [31:0] dbus_D0,
   input  logic        dbus_OFCMD0,
   output logic [1:0]  dbus_OFRESP0,
   output logic        irq
);
   typedef enum logic [1:0] {IDLE, RD_DATA, WR_DATA} state_t;
   state_t      state_q, state_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] count_q, count_d, compare_q, compare_d, rdata_q, rdata_d;
   logic        match_q, match_d;
   logic [15:0] presc_q, presc_d;
   logic [1:0]  off_q, off_d;
   logic        req, ok, accept, wr, tick, hit;
   logic [31:0] inc, rsel;
   always_comb begin
      req       = dbus_REQCMD0 == 2'd1 || dbus_REQCMD0 == 2'd2;
      ok        = dbus_A0[31:4] == BASE_ADDR[31:4] && dbus_SI0 == 2'd2 && dbus_A0[1:0] == 2'b00 && dbus_SC0 == 4'd0;
      accept    = RST && state_q == IDLE && req && ok;
      wr        = state_q == WR_DATA && dbus_OFCMD0;
      rsel      = dbus_A0[3:2] == 2'd0 ? {29'd0, ctrl_q} :
                  dbus_A0[3:2] == 2'd1 ? count_q :
                  dbus_A0[3:2] == 2'd2 ? compare_q : {31'd0, match_q};
      tick      = ctrl_q[0] && presc_q == 16'(PRESCALE - 1);
      presc_d   = (!ctrl_q[0] || tick) ? 16'd0 : presc_q + 16'd1;
      inc       = count_q + 32'd1;
      // match is judged against the COMPARE value held before any same-edge write
      hit       = tick && inc == compare_q;
      // a bus write to COUNT wins over increment and auto-reload
      count_d   = (wr && off_q == 2'd1) ? dbus_D0 : (hit && ctrl_q[1]) ? 32'd0 : tick ? inc : count_q;
      compare_d = (wr && off_q == 2'd2) ? dbus_D0 : compare_q;
      ctrl_d    = (wr && off_q == 2'd0) ? dbus_D0[2:0] : ctrl_q;
      // a new match wins over a same-edge W1C
      match_d   = hit | (match_q & ~(wr && off_q == 2'd3 && dbus_D0[0]));
      rdata_d   = accept ? rsel : rdata_q;
      off_d     = accept ? dbus_A0[3:2] : off_q;
      state_d   = state_q == IDLE    ? (accept ? (dbus_REQCMD0 == 2'd1 ? RD_DATA : WR_DATA) : IDLE) :
                  state_q == RD_DATA ? (dbus_IFCMD0 ? IDLE : RD_DATA) :
                  (dbus_OFCMD0 ? IDLE : WR_DATA);
      // WAIT while in reset or busy with a data phase; ERR for anything not decodable
      dbus_REQRESP0 = (!RST || state_q != IDLE || dbus_REQCMD0 == 2'd0) ? 2'd0 : accept ? 2'd1 : 2'd2;
      dbus_IFRESP0  = state_q == RD_DATA ? 2'd1 : 2'd0;
      dbus_Q0       = state_q == RD_DATA ? rdata_q : 32'd0;
      dbus_OFRESP0  = wr ? 2'd1 : 2'd0;
      irq           = match_q & ctrl_q[2];
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         ctrl_q    <= 3'd0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         presc_q   <= 16'd0;
         rdata_q   <= 32'd0;
         off_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
         presc_q   <= presc_d;
         rdata_q   <= rdata_d;
         off_q     <= off_d;
      end
   end
endmodule

// File: doc/codix_risc_dbus_timer.md
# codix_risc_dbus_timer

Memory-mapped 32-bit timer that is a responder on the core data bus (dbus), the opposite end of the request/data handshake the core initiates. It decodes a 16-byte register window, answers single-beat word reads and writes, runs a prescaled up-counter with compare/auto-reload, and drives the core `irq` input. It sits in the platform next to the memory responder.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: window base; bits [3:0] ignored.
- `PRESCALE`, default 1: enabled cycles per counter increment (1..65535).
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  reset: asynchronous assert, active-low.
- `dbus_A0`  in  32  request byte address.
- `dbus_SI0`  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
- `dbus_SC0`  in  4  extra beats; only 0 (single beat) supported.
- `dbus_REQCMD0`  in  2  0 IDLE, 1 READ, 2 WRITE, 3 reserved.
- `dbus_REQRESP0`  out  2  0 WAIT, 1 ACK, 2 ERR.
- `dbus_Q0`  out  32  read data.
- `dbus_IFCMD0`  in  1  initiator takes read data this cycle.
- `dbus_IFRESP0`  out  2  0 NONE, 1 OK (Q0 valid).
- `dbus_D0`  in  32  write data.
- `dbus_OFCMD0`  in  1  write data valid this cycle.
- `dbus_OFRESP0`  out  2  0 NONE, 1 OK.
- `irq`  out  1  interrupt to core, level, active-high.

## Operation
- Registers (offset A0[3:2]): 0x0 CTRL {bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, rest RAZ/WI}; 0x4 COUNT (RW); 0x8 COMPARE (RW); 0xC STATUS {bit0 MATCH, W1C; rest RAZ}.
- `irq` = STATUS.MATCH & CTRL.IRQEN, from registers only.
- FSM states IDLE, RD_DATA, WR_DATA.
- IDLE, REQCMD0 in {READ, WRITE}: if A0[31:4]==BASE_ADDR[31:4], SI0==2, A0[1:0]==0, SC0==0 -> REQRESP0=ACK; READ -> RD_DATA with selected register snapshotted into Q0 register; WRITE -> WR_DATA with offset latched. Otherwise REQRESP0=ERR, stay IDLE, no data phase, no state change.
- IDLE, REQCMD0==3 -> ERR. IDLE, REQCMD0==0 -> WAIT.
- RD_DATA: IFRESP0=OK, Q0 = snapshot; when IFCMD0=1 -> IDLE at that edge. REQRESP0=WAIT for any new request.
- WR_DATA: when OFCMD0=1, OFRESP0=OK same cycle (combinational), register written at that edge, -> IDLE. REQRESP0=WAIT while here.
- Counter: prescaler counts enabled cycles 0..PRESCALE-1; on terminal value COUNT increments (mod 2^32). Clearing EN resets the prescaler; COUNT holds.
- Match: at increment edge, if new COUNT value equals COMPARE -> MATCH set; if AUTORELOAD, COUNT loads 0 instead of the matching value on the following increment-free edge? No: with AUTORELOAD, COUNT is written 0 at the increment edge that reaches COMPARE (MATCH still set).
- Collisions: bus write to COUNT beats increment/reload; MATCH set beats W1C in same edge; match compares against pre-write COMPARE.
- Q0 = 0 whenever IFRESP0 != OK.

## Timing
- Reset values: REQRESP0=WAIT, IFRESP0=NONE, OFRESP0=NONE, Q0=0, irq=0; CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescaler=0, FSM=IDLE.
- Request accept: ACK/ERR combinational in the request cycle.
- Read: data valid from the cycle after ACK; minimum 2 cycles request-to-return-IDLE.
- Write: register visible the cycle after OFCMD0 cycle.
- `irq` rises one cycle after the MATCH-setting edge; falls one cycle after W1C or IRQEN clear.
- Reset asserted mid data phase: FSM to IDLE immediately, pending transfer dropped, no register update.
- Back-to-back: new request accepted in the first cycle after returning to IDLE.

## Test plan
- Reset: hold RST=0, drive random bus inputs -> all outputs at reset values; read COMPARE -> 32'hFFFF_FFFF.
- Write COMPARE=5, CTRL=0x7, PRESCALE=1 -> irq rises 1 cycle after COUNT reaches 5, COUNT wraps to 0; W1C STATUS=1 -> irq low next cycle.
- PRESCALE=3, COMPARE=2, EN only -> MATCH sets after 6 enabled cycles, COUNT continues to 3, irq stays 0.
- Errors: READ at BASE+0x10, SI0=0, A0=BASE+0x2, SC0=1, REQCMD0=3 -> each ERR, no data phase, registers unchanged.
- Read with IFCMD0 held low 4 cycles -> IFRESP0=OK and Q0 stable 4 cycles, new request gets WAIT, IDLE after IFCMD0=1.
- Write COUNT=0x10 in same edge as increment, and W1C STATUS in same edge as new match -> COUNT=0x10, MATCH=1; reset mid WR_DATA -> no write.
